// File: rtl/fifo_ctrl_pkg.sv
// fifo_port_ctrl shared definitions.
// State encoding, last-op and grant constants.
package fifo_ctrl_pkg;

  localparam int WORD_SIZE = 8;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WR_HI = 3'd1,
    ST_WR_LO = 3'd2,
    ST_RD_HI = 3'd3,
    ST_RD_LO = 3'd4,
    ST_FLUSH = 3'd5
  } state_e;

  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

  localparam logic GNT_A = 1'b0;
  localparam logic GNT_B = 1'b1;

endpackage

// File: rtl/fifo_port_ctrl_rr_arb2.sv
// Two-way round-robin producer arbiter.
// Grant is combinational; last_grant moves on accept.
module rr_arb2
  import fifo_ctrl_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_a_i,
  input  logic req_b_i,
  input  logic en_i,
  output logic gnt_a_o,
  output logic gnt_b_o
);

  logic last_q;

  assign gnt_a_o = req_a_i & (!req_b_i | (last_q == GNT_B));
  assign gnt_b_o = req_b_i & !gnt_a_o;

  // remember who won the last accepted write
  always_ff @(posedge clk) begin
    if (reset) begin
      last_q <= GNT_B;
    end else if (en_i) begin
      last_q <= gnt_b_o ? GNT_B : GNT_A;
    end
  end

endmodule

// File: rtl/fifo_port_ctrl.sv
// Sequencer/arbiter for the edge-strobed byte FIFO.
// Two producers, one consumer, spaced strobes, flush.
module fifo_port_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int WORD_SIZE = fifo_ctrl_pkg::WORD_SIZE
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_valid,
  input  logic [WORD_SIZE-1:0] a_data,
  output logic                 a_ready,
  input  logic                 b_valid,
  input  logic [WORD_SIZE-1:0] b_data,
  output logic                 b_ready,
  output logic                 rd_valid,
  output logic [WORD_SIZE-1:0] rd_data,
  input  logic                 rd_ready,
  input  logic                 flush,
  output logic [WORD_SIZE-1:0] fifo_d,
  output logic                 fifo_write,
  output logic                 fifo_read,
  output logic                 fifo_reset,
  input  logic [WORD_SIZE-1:0] fifo_q,
  input  logic                 fifo_empty,
  input  logic                 fifo_full
);

  state_e               state_q;
  logic                 last_op_q;
  logic                 flush_pend_q;
  logic                 wr_q;
  logic                 rd_q;
  logic                 rd_valid_q;
  logic [WORD_SIZE-1:0] rd_data_q;
  logic [WORD_SIZE-1:0] fifo_d_q;

  logic idle;
  logic wr_cand;
  logic rd_cand;
  logic do_flush;
  logic do_wr;
  logic do_rd;
  logic gnt_a;
  logic gnt_b;

  assign idle    = (state_q == ST_IDLE) & !reset;
  assign wr_cand = (a_valid | b_valid) & !fifo_full;
  assign rd_cand = !fifo_empty & (!rd_valid_q | rd_ready);

  assign do_flush = idle & flush_pend_q;
  assign do_wr = idle & !flush_pend_q & wr_cand
               & (!rd_cand | (last_op_q == OP_READ));
  assign do_rd = idle & !flush_pend_q & rd_cand
               & (!wr_cand | (last_op_q == OP_WRITE));

  rr_arb2 u_arb (
    .clk     (clk),
    .reset   (reset),
    .req_a_i (a_valid),
    .req_b_i (b_valid),
    .en_i    (do_wr),
    .gnt_a_o (gnt_a),
    .gnt_b_o (gnt_b)
  );

  assign a_ready    = do_wr & gnt_a;
  assign b_ready    = do_wr & gnt_b;
  assign fifo_write = wr_q;
  assign fifo_read  = rd_q;
  assign fifo_reset = reset | (state_q == ST_FLUSH);
  assign fifo_d     = fifo_d_q;
  assign rd_valid   = rd_valid_q;
  assign rd_data    = rd_data_q;

  // op sequencer: one decision in IDLE, then hi/lo strobe
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      last_op_q    <= OP_READ;
      flush_pend_q <= 1'b0;
      wr_q         <= 1'b0;
      rd_q         <= 1'b0;
    end else begin
      wr_q <= do_wr;
      rd_q <= do_rd;
      unique case (state_q)
        ST_IDLE: begin
          if (do_flush)   state_q <= ST_FLUSH;
          else if (do_wr) state_q <= ST_WR_HI;
          else if (do_rd) state_q <= ST_RD_HI;
        end
        ST_WR_HI: state_q <= ST_WR_LO;
        ST_RD_HI: state_q <= ST_RD_LO;
        default:  state_q <= ST_IDLE;
      endcase
      if (do_wr)      last_op_q <= OP_WRITE;
      else if (do_rd) last_op_q <= OP_READ;
      if (state_q == ST_FLUSH) flush_pend_q <= 1'b0;
      else if (flush)          flush_pend_q <= 1'b1;
    end
  end

  // write data latch and consumer output word
  always_ff @(posedge clk) begin
    if (reset) begin
      fifo_d_q   <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      if (do_wr) fifo_d_q <= gnt_a ? a_data : b_data;
      if (state_q == ST_FLUSH) begin
        rd_valid_q <= 1'b0;
      end else if (do_rd) begin
        rd_valid_q <= 1'b1;
        rd_data_q  <= fifo_q;
      end else if (rd_valid_q & rd_ready) begin
        rd_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fifo_port_ctrl.sv
// Bench for fifo_port_ctrl with a 4-entry FIFO model.
// Reference model works at op/decision level.
module tb_fifo_port_ctrl;

  localparam int W = 8;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic         a_valid, b_valid, rd_ready, flush;
  logic [W-1:0] a_data, b_data;
  logic         a_ready, b_ready, rd_valid;
  logic         fifo_write, fifo_read, fifo_reset;
  logic [W-1:0] rd_data, fifo_d, fifo_q;
  logic         fifo_empty, fifo_full;

  int n_tests = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fifo_port_ctrl #(.WORD_SIZE(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .a_valid    (a_valid),
    .a_data     (a_data),
    .a_ready    (a_ready),
    .b_valid    (b_valid),
    .b_data     (b_data),
    .b_ready    (b_ready),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .rd_ready   (rd_ready),
    .flush      (flush),
    .fifo_d     (fifo_d),
    .fifo_write (fifo_write),
    .fifo_read  (fifo_read),
    .fifo_reset (fifo_reset),
    .fifo_q     (fifo_q),
    .fifo_empty (fifo_empty),
    .fifo_full  (fifo_full)
  );

  task automatic tb_chk(input string tag,
                        input logic [31:0] got,
                        input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // edge-strobed FIFO: acts on rising strobe edges, write wins
  logic [W-1:0] mem [DEPTH];
  logic [1:0]   f_rp = 2'd0;
  logic [1:0]   f_wp = 2'd0;
  int           f_cnt = 0;
  bit           f_pw = 1'b0;
  bit           f_pr = 1'b0;

  always @(posedge clk) begin
    f_pw <= fifo_write;
    f_pr <= fifo_read;
    if (fifo_reset) begin
      f_cnt <= 0;
      f_rp  <= 2'd0;
      f_wp  <= 2'd0;
    end else if (fifo_write && !f_pw) begin
      if (f_cnt < DEPTH) begin
        mem[f_wp] <= fifo_d;
        f_wp      <= f_wp + 2'd1;
        f_cnt     <= f_cnt + 1;
      end
    end else if (fifo_read && !f_pr && f_cnt > 0) begin
      f_rp  <= f_rp + 2'd1;
      f_cnt <= f_cnt - 1;
    end
  end

  assign fifo_q     = mem[f_rp];
  assign fifo_empty = (f_cnt == 0);
  assign fifo_full  = (f_cnt == DEPTH);

  // reference model: decision points and expected outputs
  int           m_wait;
  bit           m_sw, m_sr, m_fl, m_fp, m_lw, m_lgb, m_rdv;
  logic [W-1:0] m_rdd, m_d, m_got;
  bit           wc, pc, dw, dr, df, win_b;
  logic [W-1:0] sb [$];
  int           acc_a = 0;
  int           acc_b = 0;
  int           acc_rd = 0;

  always @(negedge clk) begin
    if (reset) begin
      m_wait = 0;
      m_sw = 0; m_sr = 0; m_fl = 0; m_fp = 0;
      m_lw = 0; m_lgb = 1; m_rdv = 0;
      m_rdd = '0; m_d = '0;
      sb.delete();
    end else begin
      dw = 0; dr = 0; df = 0; win_b = 0;
      if (m_wait == 0 && !m_fl) begin
        if (m_fp) begin
          df = 1;
        end else begin
          wc = (a_valid || b_valid) && !fifo_full;
          pc = !fifo_empty && (!m_rdv || rd_ready);
          if (wc && pc) begin
            dw = !m_lw;
            dr = m_lw;
          end else begin
            dw = wc;
            dr = pc;
          end
          win_b = b_valid && (!a_valid || !m_lgb);
        end
      end
      tb_chk("a_ready", 32'(a_ready), 32'(dw && !win_b));
      tb_chk("b_ready", 32'(b_ready), 32'(dw && win_b));
      tb_chk("fifo_write", 32'(fifo_write), 32'(m_sw));
      tb_chk("fifo_read", 32'(fifo_read), 32'(m_sr));
      tb_chk("fifo_reset", 32'(fifo_reset), 32'(m_fl));
      tb_chk("strobe_overlap", 32'(fifo_write && fifo_read), 32'd0);
      tb_chk("rd_valid", 32'(rd_valid), 32'(m_rdv));
      if (m_rdv) tb_chk("rd_data", 32'(rd_data), 32'(m_rdd));
      tb_chk("fifo_d", 32'(fifo_d), 32'(m_d));

      if (a_valid && a_ready) begin
        sb.push_back(a_data);
        acc_a++;
      end
      if (b_valid && b_ready) begin
        sb.push_back(b_data);
        acc_b++;
      end
      if (rd_valid && rd_ready) begin
        acc_rd++;
        if (sb.size() == 0) begin
          tb_chk("sb_underflow", 32'(sb.size()), 32'd1);
        end else begin
          m_got = sb.pop_front();
          tb_chk("rd_order", 32'(rd_data), 32'(m_got));
        end
      end
      if (m_fl) sb.delete();

      if (m_fl) begin
        m_rdv = 0;
      end else if (dr) begin
        m_rdv = 1;
        m_rdd = fifo_q;
      end else if (m_rdv && rd_ready) begin
        m_rdv = 0;
      end
      if (m_fl)       m_fp = 0;
      else if (flush) m_fp = 1;
      if (dw) begin
        m_d   = win_b ? b_data : a_data;
        m_lgb = win_b;
        m_lw  = 1;
      end
      if (dr) m_lw = 0;
      if (dw || dr)      m_wait = 2;
      else if (df)       m_wait = 1;
      else if (m_wait > 0) m_wait--;
      m_sw = dw;
      m_sr = dr;
      m_fl = df;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [W-1:0] d);
    int n0;
    n0 = acc_a;
    a_valid = 1'b1;
    a_data  = d;
    for (int i = 0; i < 30 && acc_a == n0; i++) cyc();
    tb_chk("push_a_timeout", 32'(acc_a), 32'(n0 + 1));
    a_valid = 1'b0;
  endtask

  task automatic do_flush();
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    repeat (8) cyc();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout");
    $fatal(1, "bench timeout");
  end

  int           a0, b0, r0, k;
  logic [W-1:0] exp_w;

  initial begin
    reset = 1'b1;
    a_valid = 1'b1; b_valid = 1'b1;
    a_data = 8'h5A; b_data = 8'hA5;
    rd_ready = 1'b1; flush = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    tb_chk("rst_a_ready", 32'(a_ready), 32'd0);
    tb_chk("rst_b_ready", 32'(b_ready), 32'd0);
    tb_chk("rst_rd_valid", 32'(rd_valid), 32'd0);
    tb_chk("rst_write", 32'(fifo_write), 32'd0);
    tb_chk("rst_read", 32'(fifo_read), 32'd0);
    tb_chk("rst_rd_data", 32'(rd_data), 32'd0);
    tb_chk("rst_fifo_d", 32'(fifo_d), 32'd0);
    tb_chk("rst_fifo_reset", 32'(fifo_reset), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b0;
    a_valid = 1'b0; b_valid = 1'b0; rd_ready = 1'b0;

    // A pushes three words, consumer idle
    push_a(8'h11);
    push_a(8'h22);
    push_a(8'h33);
    repeat (6) cyc();
    tb_chk("t1_held", 32'(f_cnt + int'(rd_valid)), 32'd3);
    tb_chk("t1_head", 32'(rd_data), 32'h11);

    // both producers, consumer off: B first, then alternate
    do_flush();
    a0 = acc_a; b0 = acc_b;
    a_valid = 1'b1; b_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      a_data = 8'hA0 + 8'(acc_a - a0);
      b_data = 8'hB0 + 8'(acc_b - b0);
      cyc();
    end
    tb_chk("t2_a_cnt", 32'(acc_a - a0), 32'd2);
    tb_chk("t2_b_cnt", 32'(acc_b - b0), 32'd3);
    tb_chk("t2_full", 32'(fifo_full), 32'd1);

    // full FIFO stalls A; held word stays put
    b_valid = 1'b0;
    a0 = acc_a;
    repeat (10) cyc();
    tb_chk("t3_stall", 32'(acc_a - a0), 32'd0);
    exp_w = 8'hB0;
    tb_chk("t5_stable", 32'(rd_data), 32'(exp_w));
    tb_chk("t5_valid", 32'(rd_valid), 32'd1);
    r0 = acc_rd;
    rd_ready = 1'b1;
    for (int i = 0; i < 20 && acc_rd == r0; i++) cyc();
    rd_ready = 1'b0;
    tb_chk("t3_rd_hs", 32'(acc_rd - r0), 32'd1);
    repeat (12) cyc();
    tb_chk("t3_one_more", 32'(acc_a - a0), 32'd1);
    a_valid = 1'b0;

    // producers and consumer both active
    do_flush();
    r0 = acc_rd;
    rd_ready = 1'b1;
    for (int i = 0; i < 60; i++) begin
      a_valid = 1'b1; b_valid = 1'b1;
      a_data = 8'($urandom); b_data = 8'($urandom);
      cyc();
    end
    tb_chk("t4_progress", 32'(acc_rd - r0 >= 8), 32'd1);

    // flush pulsed while a write strobe is high
    a_valid = 1'b0; b_valid = 1'b0; rd_ready = 1'b0;
    do_flush();
    a_valid = 1'b1; a_data = 8'h77;
    k = 0;
    while (k < 20 && !fifo_write) begin
      cyc();
      k++;
    end
    tb_chk("t6_wr_seen", 32'(fifo_write), 32'd1);
    flush = 1'b1; a_valid = 1'b0;
    cyc();
    flush = 1'b0;
    tb_chk("t6_wr_done", 32'(f_cnt), 32'd1);
    tb_chk("t6_rst_early", 32'(fifo_reset), 32'd0);
    cyc();
    cyc();
    tb_chk("t6_flush", 32'(fifo_reset), 32'd1);
    tb_chk("t6_strobes", 32'({fifo_write, fifo_read}), 32'd0);
    cyc();
    tb_chk("t6_rst_len", 32'(fifo_reset), 32'd0);
    tb_chk("t6_empty", 32'(fifo_empty), 32'd1);
    tb_chk("t6_rdv", 32'(rd_valid), 32'd0);

    // random traffic with occasional flush
    for (int i = 0; i < 1500; i++) begin
      a_valid  = ($urandom_range(0, 3) != 0);
      b_valid  = ($urandom_range(0, 3) != 0);
      a_data   = 8'($urandom);
      b_data   = 8'($urandom);
      rd_ready = ($urandom_range(0, 9) < 7);
      flush    = ($urandom_range(0, 63) == 0);
      cyc();
    end

    // drain everything that was accepted
    a_valid = 1'b0; b_valid = 1'b0; flush = 1'b0;
    rd_ready = 1'b1;
    repeat (40) cyc();
    tb_chk("drain_sb", 32'(sb.size()), 32'd0);
    tb_chk("drain_fifo", 32'(fifo_empty), 32'd1);
    tb_chk("drain_rdv", 32'(rd_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
